// File: rtl/regfile_2r1w_pkg.sv
// Shared constants and clear-FSM state encoding for the 2-read/1-write register file.
package regfile_2r1w_pkg;

    localparam int DATA_WIDTH_DFLT = 32;
    localparam int ADDR_WIDTH_DFLT = 5;
    localparam bit ZERO_REG_DFLT   = 1'b1;
    localparam int NUM_RD_PORTS    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Write, read, and clear signals for regfile_2r1w; the master drives requests and the slave returns read data.
interface regfile_2r1w_if
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr_a;
    logic [ADDR_WIDTH-1:0] raddr_b;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;
    logic                  clr_start;
    logic                  busy;

    modport master (
        output we, waddr, wdata, raddr_a, raddr_b, clr_start,
        input  rdata_a, rdata_b, busy
    );

    modport slave (
        input  we, waddr, wdata, raddr_a, raddr_b, clr_start,
        output rdata_a, rdata_b, busy
    );
endinterface

// File: rtl/regfile_clr_fsm.sv
// Clear sweep controller: walks every entry once, zeroing one per cycle while busy.
module regfile_clr_fsm
    import regfile_2r1w_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_en,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    clr_state_e            state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;

    // Reset lands in CLEAR so the array is scrubbed without needing its own reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_en   = busy;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports, one write port with bypass, and a sweep clear.
module regfile_2r1w
    import regfile_2r1w_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter bit ZERO_REG   = ZERO_REG_DFLT
) (
    input  logic           clk,
    input  logic           rst,
    regfile_2r1w_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  busy;
    logic                  clr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0] raddr;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rdata;

    regfile_clr_fsm #(.ADDR_WIDTH(ADDR_WIDTH)) u_clr (
        .clk       (clk),
        .rst       (rst),
        .clr_start (bus.clr_start),
        .busy      (busy),
        .clr_en    (clr_en),
        .clr_addr  (clr_addr)
    );

    assign wr_en = bus.we && !busy && !(ZERO_REG && (bus.waddr == '0));

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en && !rst) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
    end

    assign raddr[0] = bus.raddr_a;
    assign raddr[1] = bus.raddr_b;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [DATA_WIDTH-1:0] rd;
        // Later assignments take priority: the zero-register and busy masks override the bypass.
        always_comb begin
            rd = mem_q[raddr[p]];
            if (bus.we && (bus.waddr == raddr[p])) rd = bus.wdata;
            if (busy || (ZERO_REG && (raddr[p] == '0))) rd = '0;
        end
        assign rdata[p] = rd;
    end

    assign bus.rdata_a = rdata[0];
    assign bus.rdata_b = rdata[1];
    assign bus.busy    = busy;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: a table of write/read vectors plus reset, clear and restart sequences.
module tb_regfile_2r1w;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    regfile_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
    regfile_2r1w_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();

    // The second instance (ordinary entry 0) receives the same stimulus as the first.
    assign bus1.we        = bus0.we;
    assign bus1.waddr     = bus0.waddr;
    assign bus1.wdata     = bus0.wdata;
    assign bus1.raddr_a   = bus0.raddr_a;
    assign bus1.raddr_b   = bus0.raddr_b;
    assign bus1.clr_start = bus0.clr_start;

    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [31:0] ea_nz;
        string       name;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive busy cycles sampled at negedges; leaves inputs idle and re-syncs to posedge+1.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus0.busy !== 1'b1) break;
            n++;
            chk("busy_rdata_a", bus0.rdata_a, 32'h0);
            tick();
        end
        bus0.we        = 1'b0;
        bus0.clr_start = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            bus0.raddr_a = 5'(i);
            bus0.raddr_b = 5'(31 - i);
            @(negedge clk);
            chk($sformatf("%s_a_%0d", tag, i), bus0.rdata_a, 32'h0);
            chk($sformatf("%s_b_%0d", tag, 31 - i), bus0.rdata_b, 32'h0);
            chk($sformatf("%s_nz_%0d", tag, i), bus1.rdata_a, 32'h0);
            tick();
        end
    endtask

    initial begin
        int n;
        passed = 0;
        total  = 0;

        vec[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd31, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, "wr7_bypass"};
        vec[1] = '{1'b1, 5'd31, 32'h12345678, 5'd7,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, "wr31_bypass"};
        vec[2] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, "rd7_rd31"};
        vec[3] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd3,  32'h0,        32'h0,        32'h0,        "rd3_old"};
        vec[4] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, "wr3_dual_bypass"};
        vec[5] = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd7,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5, "rd3_committed"};
        vec[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd3,  32'h0,        32'hA5A5A5A5, 32'hFFFFFFFF, "wr0_bypass"};
        vec[7] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd31, 32'h0,        32'h12345678, 32'hFFFFFFFF, "rd0_after"};
        vec[8] = '{1'b1, 5'd5,  32'h00000011, 5'd5,  5'd6,  32'h00000011, 32'h0,        32'h00000011, "wr5_port_a_only"};
        vec[9] = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd5,  32'h0,        32'h00000011, 32'h0,        "rd6_rd5"};

        rst            = 1'b1;
        bus0.we        = 1'b0;
        bus0.waddr     = '0;
        bus0.wdata     = '0;
        bus0.raddr_a   = '0;
        bus0.raddr_b   = '0;
        bus0.clr_start = 1'b0;

        // Reset: busy during and after, then exactly 32 sweep cycles.
        tick();
        @(negedge clk);
        chk("busy_in_reset", 32'(bus0.busy), 32'h1);
        tick();
        rst = 1'b0;
        count_busy(n);
        chk("reset_sweep_len", 32'(n), 32'd32);
        check_all_zero("post_reset");

        // Table-driven write/read/bypass vectors.
        for (int i = 0; i < 10; i++) begin
            bus0.we      = vec[i].we;
            bus0.waddr   = vec[i].waddr;
            bus0.wdata   = vec[i].wdata;
            bus0.raddr_a = vec[i].ra;
            bus0.raddr_b = vec[i].rb;
            @(negedge clk);
            chk({vec[i].name, "_a"},  bus0.rdata_a, vec[i].ea);
            chk({vec[i].name, "_b"},  bus0.rdata_b, vec[i].eb);
            chk({vec[i].name, "_nz"}, bus1.rdata_a, vec[i].ea_nz);
            tick();
        end
        bus0.we = 1'b0;

        // Clear mid-use: writes during sweep ignored, second clr_start ignored.
        for (int i = 1; i <= 4; i++) begin
            bus0.we    = 1'b1;
            bus0.waddr = 5'(i);
            bus0.wdata = 32'(i);
            tick();
        end
        bus0.we        = 1'b0;
        bus0.raddr_a   = 5'd2;
        bus0.raddr_b   = 5'd4;
        bus0.clr_start = 1'b1;
        @(negedge clk);
        chk("fill_rd2", bus0.rdata_a, 32'h2);
        chk("fill_rd4", bus0.rdata_b, 32'h4);
        chk("idle_busy", 32'(bus0.busy), 32'h0);
        tick();
        bus0.clr_start = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            bus0.we        = 1'b1;
            bus0.waddr     = 5'((k % 4) + 1);
            bus0.wdata     = 32'hDEAD0000 | 32'(k);
            bus0.raddr_a   = bus0.waddr;
            bus0.raddr_b   = 5'd4;
            bus0.clr_start = (k == 9);
            @(negedge clk);
            if (bus0.busy !== 1'b1) break;
            n++;
            chk("clr_byp_off_a", bus0.rdata_a, 32'h0);
            chk("clr_rd_b", bus0.rdata_b, 32'h0);
            tick();
        end
        bus0.we        = 1'b0;
        bus0.clr_start = 1'b0;
        tick();
        chk("clr_sweep_len", 32'(n), 32'd32);
        check_all_zero("post_clear");

        // Write plus clr_start in one IDLE cycle, then reset at sweep cycle 20.
        bus0.we        = 1'b1;
        bus0.waddr     = 5'd9;
        bus0.wdata     = 32'h55;
        bus0.raddr_a   = 5'd9;
        bus0.clr_start = 1'b1;
        @(negedge clk);
        chk("wr_clr_bypass", bus0.rdata_a, 32'h55);
        tick();
        bus0.we        = 1'b0;
        bus0.clr_start = 1'b0;
        n = 0;
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            if (bus0.busy === 1'b1) n++;
            tick();
        end
        chk("sweep_pre_rst", 32'(n), 32'd19);
        rst = 1'b1;
        @(negedge clk);
        chk("busy_rst_mid", 32'(bus0.busy), 32'h1);
        tick();
        rst = 1'b0;
        count_busy(n);
        chk("rst_mid_sweep_len", 32'(n), 32'd32);
        bus0.raddr_a = 5'd9;
        @(negedge clk);
        chk("rd9_cleared", bus0.rdata_a, 32'h0);
        chk("rd9_cleared_nz", bus1.rdata_a, 32'h0);
        tick();

        // Writes resume after the sweep.
        bus0.we    = 1'b1;
        bus0.waddr = 5'd9;
        bus0.wdata = 32'h77;
        tick();
        bus0.we = 1'b0;
        @(negedge clk);
        chk("rd9_after_sweep", bus0.rdata_a, 32'h77);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
